// File: rtl/ram32x4_pkg.sv
// Shared sizes and FSM state encoding for the 32x4 RAM and its access controller.
package ram32x4_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_DEPTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_CAPTURE,
        CLEAR
    } access_state_t;

endpackage

// File: rtl/ram32x4.sv
// 32x4 single-port synchronous RAM: registered read (read-first), synchronous active-high reset of the output register.
module ram32x4
    import ram32x4_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RAM_ADDR_W-1:0] address,
    input  logic [RAM_DATA_W-1:0] data_in,
    input  logic                  write_enable,
    output logic [RAM_DATA_W-1:0] data_out
);

    logic [RAM_DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= mem[address];
        end
    end

endmodule

// File: rtl/ram32x4_access_ctrl.sv
// Valid/ready request controller for one ram32x4, hiding its registered-read latency.
// Optional whole-array clear sweep is built when RAM32X4_ACCESS_CTRL_CLEAR_EN is defined.
module ram32x4_access_ctrl
    import ram32x4_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clear_start,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_data_out
);

    access_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              accept;

`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clear_done_q, clear_done_d;

    // A pending clear blocks new requests so it always wins over a simultaneous request.
    assign req_ready  = (state_q == IDLE) && !clear_start;
    assign clear_done = clear_done_q;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign req_ready          = (state_q == IDLE);
    assign clear_done         = 1'b0;
`endif

    assign accept           = req_valid && req_ready;
    assign ram_address      = addr_q;
    assign ram_data_in      = din_q;
    assign ram_write_enable = we_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
            cnt_q        <= '0;
            clear_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
            cnt_q        <= cnt_d;
            clear_done_q <= clear_done_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
        cnt_d        = cnt_q;
        clear_done_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
                if (clear_start) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    din_d   = '0;
                    we_d    = 1'b1;
                    cnt_d   = '0;
                end else
`endif
                if (accept) begin
                    addr_d = req_address;
                    if (req_write) begin
                        din_d   = req_data;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            RD_WAIT: state_d = RD_CAPTURE;
            RD_CAPTURE: begin
                rsp_data_d  = ram_data_out;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
            // The address register leads the counter so each edge commits the previous address.
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    clear_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = cnt_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram32x4_access_ctrl.sv
// Directed, table-driven bench for ram32x4_access_ctrl driving a real ram32x4.
// Expectations for the clear test follow RAM32X4_ACCESS_CTRL_CLEAR_EN.
module tb_ram32x4_access_ctrl;
    import ram32x4_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ramReset;
    logic       req_valid, req_ready, req_write;
    logic [4:0] req_address;
    logic [3:0] req_data;
    logic       rsp_valid;
    logic [3:0] rsp_data;
    logic       clear_start, clear_done;
    logic [4:0] ram_address;
    logic [3:0] ram_data_in;
    logic       ram_write_enable;
    logic [3:0] ram_data_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       write;
        logic [4:0] addr;
        logic [3:0] data;
        logic [3:0] expData;
    } vec_t;

    vec_t basicTbl [6];
    vec_t clearTbl [3];

    ram32x4_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clear_start(clear_start), .clear_done(clear_done),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
    );

    ram32x4 ram (
        .clk(clk), .reset(ramReset), .address(ram_address),
        .data_in(ram_data_in), .write_enable(ram_write_enable), .data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bounded wait for ready, sampled on falling edges.
    task automatic waitReady();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // One request: writes check the registered RAM drive, reads check the 3-edge response.
    task automatic applyStimulus(input vec_t v);
        req_write   = v.write;
        req_address = v.addr;
        req_data    = v.data;
        req_valid   = 1'b1;
        waitReady();
        @(negedge clk);
        req_valid = 1'b0;
        if (v.write) begin
            checkOutput("wr_we",    32'(ram_write_enable), 32'd1);
            checkOutput("wr_addr",  32'(ram_address), 32'(v.addr));
            checkOutput("wr_din",   32'(ram_data_in), 32'(v.data));
            checkOutput("wr_busy",  32'(req_ready), 32'd0);
            @(negedge clk);
            checkOutput("wr_we_off", 32'(ram_write_enable), 32'd0);
            checkOutput("wr_ready",  32'(req_ready), 32'd1);
        end else begin
            checkOutput("rd_addr",  32'(ram_address), 32'(v.addr));
            checkOutput("rd_vld_a1", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            checkOutput("rd_vld_a2", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            checkOutput("rd_vld_a3", 32'(rsp_valid), 32'd1);
            checkOutput("rd_data",   32'(rsp_data), 32'(v.expData));
            checkOutput("rd_ready",  32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        int w;
        int weCount;
        logic accepted;

        basicTbl = '{
            '{1'b1, 5'h15, 4'hA, 4'h0},
            '{1'b1, 5'h0A, 4'h5, 4'h0},
            '{1'b0, 5'h15, 4'h0, 4'hA},
            '{1'b0, 5'h0A, 4'h0, 4'h5},
            '{1'b1, 5'h1F, 4'h7, 4'h0},
            '{1'b0, 5'h1F, 4'h0, 4'h7}
        };
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
        clearTbl = '{'{1'b0, 5'h00, 4'h0, 4'h0}, '{1'b0, 5'h1F, 4'h0, 4'h0}, '{1'b0, 5'h05, 4'h0, 4'h0}};
`else
        clearTbl = '{'{1'b0, 5'h00, 4'h0, 4'hF}, '{1'b0, 5'h1F, 4'h0, 4'hF}, '{1'b0, 5'h05, 4'h0, 4'h3}};
`endif

        reset       = 1'b0;
        ramReset    = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;
        clear_start = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_addr",  32'(ram_address), 32'd0);
        checkOutput("rst_din",   32'(ram_data_in), 32'd0);
        checkOutput("rst_we",    32'(ram_write_enable), 32'd0);
        checkOutput("rst_vld",   32'(rsp_valid), 32'd0);
        checkOutput("rst_data",  32'(rsp_data), 32'd0);
        checkOutput("rst_done",  32'(clear_done), 32'd0);
        reset    = 1'b1;
        ramReset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) applyStimulus(basicTbl[i]);

        // Continuous valid with writes: ready alternates and one write lands per two cycles.
        w         = 0;
        weCount   = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_address = 5'(16 + w);
            req_data    = 4'(w + 1);
            checkOutput("stream_ready", 32'(req_ready), 32'((i % 2) == 0));
            accepted = req_ready;
            @(negedge clk);
            weCount += int'(ram_write_enable);
            if (accepted) begin
                checkOutput("stream_addr", 32'(ram_address), 32'(16 + w));
                w++;
            end
        end
        req_valid = 1'b0;
        checkOutput("stream_count", 32'(weCount), 32'd4);
        applyStimulus('{1'b0, 5'h11, 4'h0, 4'h2});
        applyStimulus('{1'b0, 5'h13, 4'h0, 4'h4});

        for (int a = 0; a < 32; a++) applyStimulus('{1'b1, 5'(a), 4'hF, 4'h0});

        // Clear start collides with a write request to 0x05.
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 5'h05;
        req_data    = 4'h3;
`ifdef RAM32X4_ACCESS_CTRL_CLEAR_EN
        checkOutput("clr_blocks_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        clear_start = 1'b0;
        req_valid   = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checkOutput("clr_we",   32'(ram_write_enable), 32'd1);
            checkOutput("clr_addr", 32'(ram_address), 32'(k));
            checkOutput("clr_din",  32'(ram_data_in), 32'd0);
            checkOutput("clr_busy", 32'(req_ready | clear_done), 32'd0);
            @(negedge clk);
        end
        checkOutput("clr_done",     32'(clear_done), 32'd1);
        checkOutput("clr_ready",    32'(req_ready), 32'd1);
        checkOutput("clr_we_off",   32'(ram_write_enable), 32'd0);
        @(negedge clk);
        checkOutput("clr_done_off", 32'(clear_done), 32'd0);
`else
        checkOutput("noclr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        clear_start = 1'b0;
        req_valid   = 1'b0;
        checkOutput("noclr_we",   32'(ram_write_enable), 32'd1);
        checkOutput("noclr_addr", 32'(ram_address), 32'h05);
        checkOutput("noclr_din",  32'(ram_data_in), 32'h3);
        @(negedge clk);
        checkOutput("noclr_we_off", 32'(ram_write_enable), 32'd0);
        checkOutput("noclr_done",   32'(clear_done), 32'd0);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(clearTbl[i]);

        // Reset lands one edge after a read is accepted; the read must vanish.
        applyStimulus('{1'b1, 5'h03, 4'h9, 4'h0});
        req_write   = 1'b0;
        req_address = 5'h03;
        req_valid   = 1'b1;
        waitReady();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_addr", 32'(ram_address), 32'd0);
        checkOutput("mid_rst_din",  32'(ram_data_in), 32'd0);
        checkOutput("mid_rst_we",   32'(ram_write_enable), 32'd0);
        checkOutput("mid_rst_vld",  32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(rsp_data), 32'd0);
        checkOutput("mid_rst_done", 32'(clear_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("held_rst_vld", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_vld", 32'(rsp_valid), 32'd0);
        end
        applyStimulus('{1'b0, 5'h03, 4'h0, 4'h9});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
